// File: rtl/knn_label_vote.sv
// knn_label_vote
// Sequential majority vote over the K nearest-neighbour labels produced by
// the KNN core. A single equality comparator walks every (i, j) slot pair,
// so a vote over k neighbours takes k*k cycles. For each candidate slot i
// the matches are accumulated. The best count so far is kept with a strict
// greater-than test, so on a tie the candidate nearest to the query wins.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   start        single-cycle request, honoured only while idle
//   k_sel        neighbours taking part (0 or > N_NEIGHBOUR selects all)
//   labels_in    packed labels, slot i at [LABEL*(i+1)-1 : LABEL*i]
//   busy         vote in progress (including the done cycle)
//   done         one-cycle pulse when result_* has been updated
//   result_label winning label, held until the next done
//   result_count votes for result_label, held until the next done
module knn_label_vote #(
  parameter int LABEL       = 8,
  parameter int N_NEIGHBOUR = 10,
  parameter int CNT_W       = $clog2(N_NEIGHBOUR + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CNT_W-1:0]             k_sel,
  input  logic [LABEL*N_NEIGHBOUR-1:0] labels_in,
  output logic                         busy,
  output logic                         done,
  output logic [LABEL-1:0]             result_label,
  output logic [CNT_W-1:0]             result_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_NEIGHBOUR);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t                         state_reg;
  logic [LABEL*N_NEIGHBOUR-1:0]   lab_reg;
  logic [CNT_W-1:0]               k_reg;
  logic [CNT_W-1:0]               i_reg;
  logic [CNT_W-1:0]               j_reg;
  logic [CNT_W-1:0]               cnt_reg;
  logic [CNT_W-1:0]               best_cnt_reg;
  logic [LABEL-1:0]               best_label_reg;
  logic                           busy_reg;
  logic                           done_reg;
  logic [LABEL-1:0]               result_label_reg;
  logic [CNT_W-1:0]               result_count_reg;

  // Unpacked view of the captured labels so the two read ports are plain
  // array selects.
  logic [LABEL-1:0] lab_slot [N_NEIGHBOUR];

  genvar gi;
  generate
    for (gi = 0; gi < N_NEIGHBOUR; gi++) begin : g_slot
      assign lab_slot[gi] = lab_reg[LABEL*gi +: LABEL];
    end
  endgenerate

  logic [LABEL-1:0] lab_i;
  logic [LABEL-1:0] lab_j;
  logic             match;
  logic [CNT_W-1:0] tot;
  logic [CNT_W-1:0] k_last;
  logic             better;
  logic [CNT_W-1:0] k_eff;

  always_comb begin
    lab_i  = '0;
    lab_j  = '0;
    for (int s = 0; s < N_NEIGHBOUR; s++) begin
      if (i_reg == CNT_W'(s)) lab_i = lab_slot[s];
      if (j_reg == CNT_W'(s)) lab_j = lab_slot[s];
    end
    match  = (lab_i == lab_j);
    // tot is the full vote for candidate i once j reaches the last slot.
    tot    = cnt_reg + {{(CNT_W-1){1'b0}}, match};
    k_last = k_reg - ONE;
    better = (tot > best_cnt_reg);
    // Zero or an out-of-range k_sel falls back to using every slot.
    if (k_sel == '0 || k_sel > N_CNT) k_eff = N_CNT;
    else                              k_eff = k_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      lab_reg          <= '0;
      k_reg            <= '0;
      i_reg            <= '0;
      j_reg            <= '0;
      cnt_reg          <= '0;
      best_cnt_reg     <= '0;
      best_label_reg   <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      result_label_reg <= '0;
      result_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            lab_reg        <= labels_in;
            k_reg          <= k_eff;
            i_reg          <= '0;
            j_reg          <= '0;
            cnt_reg        <= '0;
            best_cnt_reg   <= '0;
            best_label_reg <= '0;
            busy_reg       <= 1'b1;
            state_reg      <= COUNT;
          end
        end

        COUNT: begin
          if (j_reg != k_last) begin
            cnt_reg <= tot;
            j_reg   <= j_reg + ONE;
          end else begin
            if (better) begin
              best_cnt_reg   <= tot;
              best_label_reg <= lab_i;
            end
            cnt_reg <= '0;
            j_reg   <= '0;
            if (i_reg == k_last) begin
              // Results take the final candidate into account directly so
              // they are valid in the same cycle done is high.
              state_reg        <= DONE;
              done_reg         <= 1'b1;
              result_label_reg <= better ? lab_i : best_label_reg;
              result_count_reg <= better ? tot   : best_cnt_reg;
            end else begin
              i_reg <= i_reg + ONE;
            end
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign result_label = result_label_reg;
  assign result_count = result_count_reg;

endmodule

// File: tb/tb_knn_label_vote.sv
// Testbench for knn_label_vote. A driver issues votes and pushes the
// reference result plus the cycle it must appear in onto a scoreboard; a
// negedge monitor checks busy, done timing, results and result hold.
module tb_knn_label_vote;

  localparam int LABEL = 8;
  localparam int NN    = 10;
  localparam int CW    = $clog2(NN + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CW-1:0]     k_sel = '0;
  logic [LABEL*NN-1:0] labels_in = '0;
  logic              busy;
  logic              done;
  logic [LABEL-1:0]  result_label;
  logic [CW-1:0]     result_count;

  knn_label_vote #(.LABEL(LABEL), .N_NEIGHBOUR(NN)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .k_sel(k_sel),
    .labels_in(labels_in),
    .busy(busy),
    .done(done),
    .result_label(result_label),
    .result_count(result_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int label;
    int count;
    int done_at;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   bz_lo = 1;
  int   bz_hi = 0;
  int   hold_label = 0;
  int   hold_count = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [LABEL*NN-1:0] pack(input int v[NN]);
    logic [LABEL*NN-1:0] r;
    r = '0;
    for (int s = 0; s < NN; s++) r[s*LABEL +: LABEL] = LABEL'(v[s]);
    return r;
  endfunction

  function automatic int eff_k(input int ksel);
    return (ksel == 0 || ksel > NN) ? NN : ksel;
  endfunction

  // Reference: histogram each of the first k labels, take the largest count,
  // and among the labels reaching it pick the one with the lowest slot.
  function automatic void ref_vote(input logic [LABEL*NN-1:0] v, input int ksel,
                                   output int lbl, output int cnt);
    int k;
    int occ[NN];
    int best;
    k = eff_k(ksel);
    best = 0;
    lbl = 0;
    for (int a = 0; a < k; a++) begin
      occ[a] = 0;
      for (int b = 0; b < k; b++)
        if (v[b*LABEL +: LABEL] == v[a*LABEL +: LABEL]) occ[a]++;
      if (occ[a] > best) best = occ[a];
    end
    for (int a = k - 1; a >= 0; a--)
      if (occ[a] == best) lbl = int'(v[a*LABEL +: LABEL]);
    cnt = best;
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after an edge while the DUT is idle.
  task automatic start_vote(input logic [LABEL*NN-1:0] v, input int ksel,
                            input bit push, output int t0, output int k);
    exp_t e;
    int   lbl;
    int   cnt;
    labels_in = v;
    k_sel     = CW'(ksel);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    k  = eff_k(ksel);
    bz_lo = t0;
    bz_hi = t0 + k * k;
    if (push) begin
      ref_vote(v, ksel, lbl, cnt);
      e.label   = lbl;
      e.count   = cnt;
      e.done_at = t0 + k * k;
      sbq.push_back(e);
      $display("vote issued: k_sel=%0d k=%0d expect label=%0d count=%0d at cycle %0d",
               ksel, k, lbl, cnt, e.done_at);
    end
  endtask

  task automatic run_vote(input logic [LABEL*NN-1:0] v, input int ksel);
    int t0;
    int k;
    start_vote(v, ksel, 1'b1, t0, k);
    wait_until(t0 + k * k + 1);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("busy", int'(busy), int'(cyc >= bz_lo && cyc <= bz_hi));
      if (sbq.size() != 0 && cyc > sbq[0].done_at) begin
        e = sbq.pop_front();
        total++;
        bad++;
        $display("FAIL missing_done: got no done want done at cycle %0d", e.done_at);
      end
      if (done) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stray_done: got done=1 want done=0 (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.done_at);
          chk("result_label", int'(result_label), e.label);
          chk("result_count", int'(result_count), e.count);
          $display("vote done: label=%0d count=%0d cycle=%0d", result_label, result_count, cyc);
          hold_label = e.label;
          hold_count = e.count;
        end
      end else begin
        chk("hold_label", int'(result_label), hold_label);
        chk("hold_count", int'(result_count), hold_count);
      end
    end
  end

  initial begin
    int tbl[NN];
    int t0;
    int k;
    logic [LABEL*NN-1:0] v;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_label", int'(result_label), 0);
    chk("reset_count", int'(result_count), 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Nominal vote
    tbl = '{3, 5, 3, 5, 5, 1, 2, 5, 7, 3};
    run_vote(pack(tbl), 10);
    // Tie: nearest wins
    tbl = '{7, 2, 7, 2, 1, 4, 6, 8, 9, 0};
    run_vote(pack(tbl), 10);
    // Reduced k
    tbl = '{4, 9, 9, 4, 4, 4, 4, 4, 4, 4};
    run_vote(pack(tbl), 3);
    // All distinct, plus out-of-range k_sel
    tbl = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_vote(pack(tbl), 10);
    run_vote(pack(tbl), 0);
    run_vote(pack(tbl), 15);

    // Start while busy with changed labels, and start during the done cycle
    tbl = '{6, 6, 1, 6, 2, 2, 2, 6, 3, 4};
    start_vote(pack(tbl), 10, 1'b1, t0, k);
    wait_until(t0 + 20);
    tbl = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    labels_in = pack(tbl);
    k_sel = CW'(2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_until(t0 + k * k);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end

    // Reset mid-vote
    tbl = '{5, 5, 5, 2, 2, 1, 0, 3, 3, 3};
    start_vote(pack(tbl), 10, 1'b0, t0, k);
    wait_until(t0 + 39);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bz_lo = 1;
    bz_hi = 0;
    hold_label = 0;
    hold_count = 0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_label", int'(result_label), 0);
    chk("rst_count", int'(result_count), 0);
    repeat (120) begin
      @(posedge clk);
      #1;
    end
    run_vote(pack(tbl), 10);

    // Randomized votes with small label alphabet to create ties
    for (int n = 0; n < 25; n++) begin
      for (int s = 0; s < NN; s++) tbl[s] = int'($urandom_range(0, 3));
      if (n % 5 == 4) tbl[0] = int'($urandom_range(0, 255));
      v = pack(tbl);
      run_vote(v, int'($urandom_range(0, 15)));
      repeat (int'($urandom_range(0, 3))) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
